// File: rtl/dma_width_engine.sv
// dma_width_engine: descriptor-driven DMA engine between a CPU_W-bit CPU stream and a
// MEM_W-bit memory stream, with width conversion through an internal CPU-word FIFO.
//
// Ports:
//   clk, resetn                      clock (rising edge), synchronous active-low reset
//   desc_valid/ready/mode/addr/len   descriptor; mode 1 = CPU->MEM, 0 = MEM->CPU
//   mem_addr_valid/ready, mem_addr,
//   mem_len                          address phase (mem_len counts MEM beats)
//   cpu_in_*  / mem_out_*            CPU->MEM data path (serializer, LSB slice first)
//   mem_in_*  / cpu_out_*            MEM->CPU data path (deserializer, LSB slice first)
//   busy, done                       busy outside IDLE; done is a one-cycle completion pulse
//   xfer_count                       delivered-word counter, present only with DMA_STATUS_EN
//
// Optional feature macro: DMA_STATUS_EN adds the xfer_count output.
module dma_width_engine #(
    parameter int unsigned CPU_W      = 8,
    parameter int unsigned MEM_W      = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic              desc_mode,
    input  logic [ADDR_W-1:0] desc_addr,
    input  logic [LEN_W-1:0]  desc_len,
    output logic              mem_addr_valid,
    input  logic              mem_addr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LEN_W-1:0]  mem_len,
    input  logic              cpu_in_valid,
    output logic              cpu_in_ready,
    input  logic [CPU_W-1:0]  cpu_in_data,
    output logic              cpu_out_valid,
    input  logic              cpu_out_ready,
    output logic [CPU_W-1:0]  cpu_out_data,
    input  logic              mem_in_valid,
    output logic              mem_in_ready,
    input  logic [MEM_W-1:0]  mem_in_data,
    output logic              mem_out_valid,
    input  logic              mem_out_ready,
    output logic [MEM_W-1:0]  mem_out_data,
`ifdef DMA_STATUS_EN
    output logic [LEN_W-1:0]  xfer_count,
`endif
    output logic              busy,
    output logic              done
);

    localparam int unsigned RATIO = CPU_W / MEM_W;
    localparam int unsigned RW    = (RATIO > 1) ? $clog2(RATIO) : 0;
    localparam int unsigned BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned CW    = LEN_W + RW + 1;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StAddr, StXfer, StDone} state_e;

    state_e state_q, state_d;

    logic              mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  mem_len_q;
    logic [CW-1:0]     len_q;      // length in CPU words
    logic [CW-1:0]     lenb_q;     // length in MEM beats
    logic [CW-1:0]     acc_q;      // CPU words accepted (CPU->MEM)
    logic [CW-1:0]     rcv_q;      // MEM beats received (MEM->CPU)
    logic [CW-1:0]     deliv_q;    // words delivered to the far side
    logic [BW-1:0]     beat_q;     // slice index, shared: only one direction is active
    logic [RATIO-1:0][MEM_W-1:0] deser_q;
    logic [RATIO-1:0][MEM_W-1:0] deser_word;
    logic [RATIO-1:0][MEM_W-1:0] head_s;

    logic [CPU_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PW:0]       wr_ptr_q, rd_ptr_q;
    logic              fifo_full, fifo_empty;
    logic [CPU_W-1:0]  head;

    logic desc_fire, in_xfer, last_beat;
    logic cpu_in_fire, mem_out_fire, mem_in_fire, cpu_out_fire;
    logic push, pop;
    logic [CPU_W-1:0]  push_data;

    // The extra pointer bit separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = fifo_q[rd_ptr_q[PW-1:0]];
    assign head_s     = head;

    assign in_xfer   = (state_q == StXfer);
    assign last_beat = (beat_q == BW'(RATIO - 1));
    assign desc_fire = desc_valid && desc_ready;

    // The serializer reads the FIFO head in place and pops only after the last beat,
    // so the FIFO alone bounds the number of words buffered.
    assign cpu_in_ready  = in_xfer && mode_q && !fifo_full && (acc_q < len_q);
    assign mem_out_valid = in_xfer && mode_q && !fifo_empty;
    assign mem_out_data  = mem_out_valid ? head_s[beat_q] : '0;

    assign mem_in_ready  = in_xfer && !mode_q && !fifo_full && (rcv_q < lenb_q);
    assign cpu_out_valid = in_xfer && !mode_q && !fifo_empty;
    assign cpu_out_data  = cpu_out_valid ? head : '0;

    assign cpu_in_fire  = cpu_in_valid && cpu_in_ready;
    assign mem_out_fire = mem_out_valid && mem_out_ready;
    assign mem_in_fire  = mem_in_valid && mem_in_ready;
    assign cpu_out_fire = cpu_out_valid && cpu_out_ready;

    always_comb begin
        deser_word         = deser_q;
        deser_word[beat_q] = mem_in_data;
    end

    assign push      = cpu_in_fire || (mem_in_fire && last_beat);
    assign push_data = mode_q ? cpu_in_data : deser_word;
    assign pop       = (mem_out_fire && last_beat) || cpu_out_fire;

    assign mem_addr = addr_q;
    assign mem_len  = mem_len_q;

    always_comb begin
        state_d        = state_q;
        desc_ready     = 1'b0;
        mem_addr_valid = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        unique case (state_q)
            StIdle: begin
                desc_ready = 1'b1;
                busy       = 1'b0;
                if (desc_valid) begin
                    state_d = (desc_len == '0) ? StDone : StAddr;
                end
            end
            StAddr: begin
                mem_addr_valid = 1'b1;
                if (mem_addr_ready) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (deliv_q == len_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mode_q    <= 1'b0;
            addr_q    <= '0;
            mem_len_q <= '0;
            len_q     <= '0;
            lenb_q    <= '0;
            acc_q     <= '0;
            rcv_q     <= '0;
            deliv_q   <= '0;
            beat_q    <= '0;
            deser_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else if (desc_fire) begin
            mode_q    <= desc_mode;
            addr_q    <= desc_addr;
            mem_len_q <= desc_len * LEN_W'(RATIO);
            len_q     <= CW'(desc_len);
            lenb_q    <= CW'(desc_len) * CW'(RATIO);
            acc_q     <= '0;
            rcv_q     <= '0;
            deliv_q   <= '0;
            beat_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            if (cpu_in_fire) begin
                acc_q <= acc_q + CW'(1);
            end
            if (mem_in_fire) begin
                rcv_q   <= rcv_q + CW'(1);
                deser_q <= deser_word;
            end
            if (mem_out_fire || mem_in_fire) begin
                beat_q <= last_beat ? '0 : beat_q + BW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                deliv_q  <= deliv_q + CW'(1);
            end
        end
    end

    // Storage needs no reset: it is only read when the pointers say it holds data.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

`ifdef DMA_STATUS_EN
    logic [LEN_W-1:0] xfer_count_q;

    always_ff @(posedge clk) begin
        if (!resetn || desc_fire) begin
            xfer_count_q <= '0;
        end else if (pop) begin
            xfer_count_q <= xfer_count_q + LEN_W'(1);
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule
